// File: rtl/ahb_mux_pkg.sv
// Shared encodings for the AHB response mux: HTRANS codes, default-subordinate
// FSM states and the stall-counter width helper.
package ahb_mux_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } dsub_state_t;

  // Bits needed to hold a stall count of 0..cycles inclusive.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/ahb_default_subordinate.sv
// Default subordinate: two-cycle ERROR sequencer for unmapped transfers and,
// when AHB_MUX_TIMEOUT_EN is defined, for subordinates that stall too long.
module ahb_default_subordinate
  import ahb_mux_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic clk,
  input  logic nReset,
  input  logic unmapped,
`ifdef AHB_MUX_TIMEOUT_EN
  input  logic stall,
`endif
  output logic err_active_c,
  output logic err_wait_c
);

  if (TimeoutCycles < 1) begin : g_bad_timeout
    $error("ahb_default_subordinate: TimeoutCycles must be at least 1");
  end

  dsub_state_t state;
  dsub_state_t state_nxt;
  logic        timeout_hit;

`ifdef AHB_MUX_TIMEOUT_EN
  localparam int unsigned CntW = cnt_width(TimeoutCycles);

  logic [CntW-1:0] stall_cnt;

  // Consecutive stall cycles of the selected subordinate; any ready cycle clears it.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      stall_cnt <= '0;
    end else if ((state == ST_IDLE) && stall) begin
      stall_cnt <= stall_cnt + CntW'(1);
    end else begin
      stall_cnt <= '0;
    end
  end

  assign timeout_hit = (state == ST_IDLE) && stall &&
                       (stall_cnt == CntW'(TimeoutCycles - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ERR2 drives HREADY high, so a new unmapped address phase can re-enter ERR1.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (unmapped || timeout_hit) state_nxt = ST_ERR1;
      ST_ERR1: state_nxt = ST_ERR2;
      ST_ERR2: state_nxt = unmapped ? ST_ERR1 : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Decoded straight from the state register so hready never depends on unmapped.
  assign err_active_c = (state != ST_IDLE);
  assign err_wait_c   = (state == ST_ERR1);

endmodule

// File: rtl/ahb_response_mux.sv
// AHB data-phase response mux with built-in default subordinate.
// Define AHB_MUX_TIMEOUT_EN to turn long subordinate stalls into an ERROR response.
module ahb_response_mux
  import ahb_mux_pkg::*;
#(
  parameter int unsigned PrphNum       = 2,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                         clk,
  input  logic                         nReset,
  input  logic [1:0]                   htrans,
  input  logic [PrphNum-1:0]           sel,
  input  logic [PrphNum*DataWidth-1:0] prph_rdata,
  input  logic [PrphNum-1:0]           prph_readyout,
  input  logic [PrphNum-1:0]           prph_resp,
  output logic [DataWidth-1:0]         hrdata,
  output logic                         hready,
  output logic                         hresp
);

  if ((PrphNum < 2) || (PrphNum > 16)) begin : g_bad_prph_num
    $error("ahb_response_mux: PrphNum must be within 2..16");
  end

  logic                 trans_active;
  logic                 sel_onehot;
  logic                 unmapped;
  logic [PrphNum-1:0]   dsel;
  logic                 dsel_busy;
  logic [DataWidth-1:0] slv_rdata;
  logic                 slv_ready;
  logic                 slv_resp;
  logic                 err_active_c;
  logic                 err_wait_c;

  always_comb begin
    trans_active = 1'b0;
    case (htrans)
      HTRANS_IDLE, HTRANS_BUSY:  trans_active = 1'b0;
      HTRANS_NONSEQ, HTRANS_SEQ: trans_active = 1'b1;
      default:                   trans_active = 1'b0;
    endcase
  end

  assign sel_onehot = $onehot(sel);
  assign unmapped   = hready && trans_active && !sel_onehot;

  // Data-phase select: only a clean one-hot active transfer reaches a subordinate.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      dsel <= '0;
    end else if (hready) begin
      dsel <= (trans_active && sel_onehot) ? sel : '0;
    end
  end

  assign dsel_busy = |dsel;

  always_comb begin
    slv_rdata = '0;
    slv_ready = 1'b0;
    slv_resp  = 1'b0;
    for (int i = 0; i < PrphNum; i++) begin
      if (dsel[i]) begin
        slv_rdata = slv_rdata | prph_rdata[i*DataWidth +: DataWidth];
        slv_ready = slv_ready | prph_readyout[i];
        slv_resp  = slv_resp  | prph_resp[i];
      end
    end
  end

  // ERROR sequencing overrides the subordinate (needed for the timeout case).
  always_comb begin
    hrdata = '0;
    hready = 1'b1;
    hresp  = 1'b0;
    if (err_active_c) begin
      hready = !err_wait_c;
      hresp  = 1'b1;
    end else if (dsel_busy) begin
      hrdata = slv_rdata;
      hready = slv_ready;
      hresp  = slv_resp;
    end
  end

  ahb_default_subordinate #(
    .TimeoutCycles(TimeoutCycles)
  ) u_dsub (
    .clk         (clk),
    .nReset      (nReset),
    .unmapped    (unmapped),
`ifdef AHB_MUX_TIMEOUT_EN
    .stall       (dsel_busy && !slv_ready),
`endif
    .err_active_c(err_active_c),
    .err_wait_c  (err_wait_c)
  );

endmodule

// File: tb/tb_ahb_response_mux.sv
// Scoreboard bench for ahb_response_mux: directed scenarios plus random traffic
// against a transfer-level reference model.
module tb_ahb_response_mux;

  localparam int unsigned P  = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_BUSY   = 2'd1;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;

  logic            clk = 1'b0;
  logic            nReset = 1'b0;
  logic [1:0]      htrans;
  logic [P-1:0]    sel;
  logic [P*DW-1:0] prph_rdata;
  logic [P-1:0]    prph_readyout;
  logic [P-1:0]    prph_resp;
  logic [DW-1:0]   hrdata;
  logic            hready;
  logic            hresp;

  always #5 clk = ~clk;

  ahb_response_mux #(
    .PrphNum(P), .DataWidth(DW), .TimeoutCycles(TO)
  ) dut (
    .clk(clk), .nReset(nReset), .htrans(htrans), .sel(sel),
    .prph_rdata(prph_rdata), .prph_readyout(prph_readyout), .prph_resp(prph_resp),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  typedef struct {
    logic          rdy;
    logic          rsp;
    logic [DW-1:0] data;
    int unsigned   id;
  } exp_t;

  exp_t          exp_q[$];
  int unsigned   vectors = 0;
  int unsigned   miscompares = 0;
  int unsigned   cycle_id = 0;
  logic [DW-1:0] rd [P];

  // Reference model: which subordinate owns the data phase, ERROR cycles left, stall length.
  int m_slave = -1;
  int m_err   = 0;
  int m_stall = 0;

  task automatic step(input logic [1:0] tr, input logic [P-1:0] s,
                      input logic [P-1:0] rdy, input logic [P-1:0] rsp,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input logic rst);
    exp_t e;
    int   idx;
    @(posedge clk);
    #1;
    htrans = tr;
    sel = s;
    prph_readyout = rdy;
    prph_resp = rsp;
    rd[0] = d0;
    rd[1] = d1;
    for (int i = 0; i < P; i++) prph_rdata[i*DW +: DW] = rd[i];
    if (rst) begin
      nReset = 1'b0;
      m_slave = -1;
      m_err = 0;
      m_stall = 0;
    end
    if (m_err == 2) begin
      e.rdy = 1'b0; e.rsp = 1'b1; e.data = '0;
    end else if (m_err == 1) begin
      e.rdy = 1'b1; e.rsp = 1'b1; e.data = '0;
    end else if (m_slave >= 0) begin
      e.rdy = rdy[m_slave]; e.rsp = rsp[m_slave]; e.data = rd[m_slave];
    end else begin
      e.rdy = 1'b1; e.rsp = 1'b0; e.data = '0;
    end
    e.id = cycle_id;
    cycle_id++;
    exp_q.push_back(e);
    if (e.rdy) begin
      m_stall = 0;
      idx = -1;
      for (int i = 0; i < P; i++) if (s[i]) idx = i;
      if (tr[1] && ($countones(s) == 1)) begin
        m_err = 0; m_slave = idx;
      end else if (tr[1]) begin
        m_err = 2; m_slave = -1;
      end else begin
        m_err = 0; m_slave = -1;
      end
    end else if (m_err == 2) begin
      m_err = 1;
    end else begin
`ifdef AHB_MUX_TIMEOUT_EN
      m_stall++;
      if (m_stall == int'(TO)) begin
        m_err = 2; m_slave = -1; m_stall = 0;
      end
`endif
    end
    if (rst) begin
      @(negedge clk);
      #1;
      nReset = 1'b1;
    end
  endtask

  // Monitor: one response per cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vectors++;
        if ((hready !== e.rdy) || (hresp !== e.rsp) || (hrdata !== e.data)) begin
          miscompares++;
          $display("FAIL cycle%0d response: got hready=%b hresp=%b hrdata=%h, want hready=%b hresp=%b hrdata=%h",
                   e.id, hready, hresp, hrdata, e.rdy, e.rsp, e.data);
        end
      end
    end
  end

  initial begin
    logic [1:0]   r_tr;
    logic [P-1:0] r_sel;
    logic [P-1:0] r_rdy;
    logic [P-1:0] r_rsp;
    int unsigned  pick;
    htrans = T_IDLE;
    sel = '0;
    prph_readyout = '1;
    prph_resp = '0;
    prph_rdata = '0;

    // Reset state, then idle
    step(T_IDLE, 2'b00, 2'b11, 2'b00, $urandom, $urandom, 1'b1);
    step(T_IDLE, 2'b00, 2'b11, 2'b00, $urandom, $urandom, 1'b0);

    // Mapped read from subordinate 1
    step(T_NONSEQ, 2'b10, 2'b11, 2'b00, $urandom, $urandom, 1'b0);
    step(T_IDLE, 2'b00, 2'b11, 2'b00, $urandom, 32'hCAFE0001, 1'b0);

    // Subordinate 0 stalls three cycles while the next address phase waits
    step(T_NONSEQ, 2'b01, 2'b11, 2'b00, $urandom, $urandom, 1'b0);
    repeat (3) step(T_NONSEQ, 2'b10, 2'b10, 2'b00, $urandom, $urandom, 1'b0);
    step(T_NONSEQ, 2'b10, 2'b11, 2'b00, 32'h0000_5A5A, $urandom, 1'b0);
    step(T_IDLE, 2'b00, 2'b11, 2'b00, $urandom, 32'h1234_5678, 1'b0);

    // Unmapped: no select, then multi-hot select
    step(T_NONSEQ, 2'b00, 2'b11, 2'b00, $urandom, $urandom, 1'b0);
    repeat (3) step(T_IDLE, 2'b00, 2'b11, 2'b00, $urandom, $urandom, 1'b0);
    step(T_SEQ, 2'b11, 2'b11, 2'b00, $urandom, $urandom, 1'b0);
    repeat (3) step(T_IDLE, 2'b00, 2'b11, 2'b00, $urandom, $urandom, 1'b0);

    // Back-to-back unmapped, second one presented in ERR2
    step(T_NONSEQ, 2'b00, 2'b11, 2'b00, $urandom, $urandom, 1'b0);
    step(T_NONSEQ, 2'b01, 2'b11, 2'b00, $urandom, $urandom, 1'b0);
    step(T_SEQ, 2'b11, 2'b11, 2'b00, $urandom, $urandom, 1'b0);
    repeat (3) step(T_IDLE, 2'b00, 2'b11, 2'b00, $urandom, $urandom, 1'b0);

    // Reset pulsed during ERR1, then a normal mapped read
    step(T_NONSEQ, 2'b00, 2'b11, 2'b00, $urandom, $urandom, 1'b0);
    step(T_NONSEQ, 2'b10, 2'b11, 2'b00, $urandom, $urandom, 1'b1);
    step(T_NONSEQ, 2'b01, 2'b11, 2'b00, $urandom, 32'hBEEF_0002, 1'b0);
    step(T_IDLE, 2'b00, 2'b11, 2'b00, 32'hBEEF_0003, $urandom, 1'b0);

    // IDLE/BUSY with a valid select never open a data phase
    step(T_BUSY, 2'b01, 2'b11, 2'b00, $urandom, $urandom, 1'b0);
    step(T_IDLE, 2'b10, 2'b00, 2'b11, $urandom, $urandom, 1'b0);
    step(T_IDLE, 2'b00, 2'b00, 2'b11, $urandom, $urandom, 1'b0);

`ifdef AHB_MUX_TIMEOUT_EN
    // Subordinate 0 never becomes ready
    step(T_NONSEQ, 2'b01, 2'b11, 2'b00, $urandom, $urandom, 1'b0);
    repeat (7) step(T_IDLE, 2'b00, 2'b10, 2'b00, $urandom, $urandom, 1'b0);
`endif

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      r_tr = 2'($urandom_range(0, 3));
      pick = $urandom_range(0, 9);
      if (pick < 7) r_sel = P'(1) << $urandom_range(0, P - 1);
      else if (pick == 7) r_sel = '0;
      else r_sel = '1;
      for (int i = 0; i < P; i++) begin
        r_rdy[i] = ($urandom_range(0, 3) != 0);
        r_rsp[i] = ($urandom_range(0, 7) == 0);
      end
      step(r_tr, r_sel, r_rdy, r_rsp, $urandom, $urandom, ($urandom_range(0, 63) == 0));
    end
    step(T_IDLE, 2'b00, 2'b11, 2'b00, $urandom, $urandom, 1'b0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d responses still pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_response_mux.md
AHB_RESPONSE_MUX -- requirements
Module: ahb_response_mux

Interface
REQ-001 SHALL have parameter PrphNum, default 2: number of subordinates, 2..16.
REQ-002 SHALL have parameter DataWidth, default 32: read-data width.
REQ-003 SHALL have parameter TimeoutCycles, default 256: stall limit, used only when AHB_MUX_TIMEOUT_EN is defined.
REQ-004 SHALL have port clk  input  1  single system clock, rising-edge.
REQ-005 SHALL have port nReset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port htrans  input  2  manager address-phase transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-007 SHALL have port sel  input  PrphNum  address-phase one-hot subordinate select from the address decoder; all-zero means unmapped.
REQ-008 SHALL have port prph_rdata  input  PrphNum*DataWidth  subordinate read data, slice i belongs to subordinate i.
REQ-009 SHALL have port prph_readyout  input  PrphNum  subordinate HREADYOUT.
REQ-010 SHALL have port prph_resp  input  PrphNum  subordinate HRESP (1=ERROR).
REQ-011 SHALL have port hrdata  output  DataWidth  read data to manager.
REQ-012 SHALL have port hready  output  1  HREADY to manager and to all subordinates.
REQ-013 SHALL have port hresp  output  1  HRESP to manager.

Function
REQ-014 SHALL hold a data-phase select register dsel (PrphNum bits), updated only on a clk edge where hready=1.
REQ-015 On that edge dsel SHALL load sel when htrans is NONSEQ/SEQ and sel is exactly one-hot; otherwise it SHALL load all-zero.
REQ-016 The transfer SHALL be flagged unmapped on that edge when htrans is NONSEQ/SEQ and sel is all-zero or multi-hot.
REQ-017 With dsel one-hot at bit i, hrdata, hready and hresp SHALL combinationally equal prph_rdata[i], prph_readyout[i] and prph_resp[i]; latency is zero.
REQ-018 With dsel all-zero and the default-subordinate FSM in IDLE, outputs SHALL be hready=1, hresp=0, hrdata=0.
REQ-019 The default-subordinate FSM SHALL have states IDLE, ERR1 and ERR2.
REQ-020 FSM transitions: IDLE->ERR1 on an unmapped flag; ERR1->ERR2 unconditionally; ERR2->ERR1 on an unmapped flag in that cycle, else ERR2->IDLE.
REQ-021 In ERR1 the outputs SHALL be hready=0, hresp=1; in ERR2 hready=1, hresp=1; in both, hrdata=0.
REQ-022 An address phase with htrans NONSEQ/SEQ presented during ERR2 SHALL be accepted normally, per AHB two-cycle ERROR rules.
REQ-023 IDLE/BUSY transfers SHALL never reach a subordinate data phase and SHALL produce a zero-wait OKAY response.
REQ-024 While hready=0, changes on sel and htrans SHALL be ignored.

Reset
REQ-025 While nReset=0, dsel SHALL be 0 and the FSM SHALL be IDLE, giving hready=1, hresp=0, hrdata=0, asynchronously.
REQ-026 Assertion of reset mid-stall or mid-ERROR SHALL abort the transfer; the first edge after release SHALL behave as from IDLE.

Configuration
REQ-027 With AHB_MUX_TIMEOUT_EN defined, a counter SHALL count consecutive cycles of hready=0 while dsel is non-zero; it SHALL clear whenever hready=1.
REQ-028 With AHB_MUX_TIMEOUT_EN defined, when the counter reaches TimeoutCycles the mux SHALL drive ERR1 then ERR2 (two-cycle ERROR) regardless of the subordinate, and SHALL then clear dsel.
REQ-029 Without AHB_MUX_TIMEOUT_EN, no counter SHALL exist, and a subordinate may stall indefinitely.

Structure
REQ-030 Package ahb_mux_pkg SHALL hold the htrans encoding constants, the FSM state enum, and the counter-width function $clog2(TimeoutCycles+1).
REQ-031 The IDLE/ERR1/ERR2 FSM and the timeout counter SHALL live in sub-module ahb_default_subordinate; the select register and the mux SHALL remain in the top.

Verification
REQ-032 PrphNum=2: NONSEQ with sel=2'b10, prph_readyout[1]=1, prph_rdata[1]=32'hCAFE0001 -> next cycle hrdata=32'hCAFE0001, hready=1, hresp=0.
REQ-033 Subordinate 0 holds readyout=0 for 3 cycles -> hready=0 for 3 cycles, then the next address phase is accepted on the cycle readyout=1.
REQ-034 NONSEQ with sel=2'b00, and separately with sel=2'b11 -> each gives hready=0/hresp=1, then hready=1/hresp=1, then IDLE.
REQ-035 Back-to-back unmapped NONSEQ with the second presented in ERR2 -> sequence ERR1, ERR2, ERR1, ERR2, IDLE.
REQ-036 nReset pulsed low during ERR1 -> hready=1, hresp=0 immediately; after release, a mapped read returns data normally.
REQ-037 With AHB_MUX_TIMEOUT_EN and TimeoutCycles=4, subordinate stalled forever -> after 4 stall cycles, a two-cycle ERROR, then hready=1, hresp=0.
